pivot_sequencer: RTL

Column-by-column pivot controller for the fixed-point Gauss-Jordan inverter. It steps the operation counter from 0 to MAT_SIZE-1. For each column it:
- fetches the column into the column-scan unit;
- runs the pivot search;
- hands the chosen pivot row to the swap/elimination engine over a valid/ready handshake.

It stops early and flags the matrix singular when a pivot search reports an all-zero candidate set.

---
 rtl/gj_pkg.sv | 32 +++
 rtl/pivot_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gj_pkg.sv
// Shared types for the fixed-point Gauss-Jordan inverter.
//   idx_w()        : index width for a given matrix dimension (matches the
//                    column-scan unit's opCnt / winnerIndex width)
//   pivot_state_t  : pivot sequencer FSM states
//   pivot_desc_t   : pivot descriptor handed to the swap/elimination engine
package gj_pkg;

    localparam int GJ_MAT_SIZE = 5;

    function automatic int idx_w(input int mat_size);
        return $clog2(mat_size) + 1;
    endfunction

    localparam int GJ_IDX_W = idx_w(GJ_MAT_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        SCAN,
        ISSUE,
        NEXT,
        FIN
    } pivot_state_t;

    typedef struct packed {
        logic [GJ_IDX_W-1:0] row;
        logic [GJ_IDX_W-1:0] col;
        logic                swap;
    } pivot_desc_t;

endpackage

// File: rtl/pivot_sequencer.sv
// Column-by-column pivot controller for the Gauss-Jordan inverter.
// Walks op_cnt from 0 to MAT_SIZE-1; for each column it fetches the column
// into the scan unit, runs the pivot search, then offers the chosen pivot row
// to the elimination engine over valid/ready. Stops early and sets the sticky
// singular flag when the search reports no usable pivot.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, abort               run control (abort is synchronous, top priority)
//   busy, done, singular       run status
//   op_cnt                     current column, drives scan unit opCnt
//   col_rd, col_idx, col_valid column fetch request / column index / data ready
//   scan_start, scan_done,
//   scan_done_rst              scan unit matchStart / matchDone / matchDoneRst
//   scan_winner, scan_error    scan unit result (absolute row) and error
//   piv_valid, piv_ready       pivot descriptor handshake
//   piv_row, piv_col, piv_swap pivot descriptor payload
module pivot_sequencer
    import gj_pkg::*;
#(
    parameter int MAT_SIZE = GJ_MAT_SIZE,
    parameter int IDX_W    = idx_w(MAT_SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             singular,
    output logic [IDX_W-1:0] op_cnt,
    output logic             col_rd,
    output logic [IDX_W-1:0] col_idx,
    input  logic             col_valid,
    output logic             scan_start,
    input  logic             scan_done,
    output logic             scan_done_rst,
    input  logic [IDX_W-1:0] scan_winner,
    input  logic             scan_error,
    output logic             piv_valid,
    input  logic             piv_ready,
    output logic [IDX_W-1:0] piv_row,
    output logic [IDX_W-1:0] piv_col,
    output logic             piv_swap
);

    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(MAT_SIZE - 1);

    pivot_state_t state, state_nxt;

    logic scan_armed;   // high from the second SCAN cycle on
    logic scan_hit;     // qualified scan_done seen this cycle
    logic scan_take;    // scan result is consumed (not overridden by abort)
    logic pivot_bad;    // search failed or winner lies above the diagonal
    logic start_acc;    // start accepted in IDLE
    logic last_col;

    assign start_acc = (state == IDLE) && start && !abort;
    assign last_col  = (op_cnt == LAST_COL);
    // Rows above op_cnt are already pivoted; a winner there is as bad as none.
    assign pivot_bad = scan_error || (scan_winner < op_cnt);
    assign scan_take = scan_hit && !abort;

    // NOTE: the state register is the only place the state changes; all
    // sequential blocks use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        scan_hit  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  if (col_valid) state_nxt = START;
            START: state_nxt = SCAN;
            SCAN: begin
                // The first SCAN cycle may still see the previous column's
                // matchDone level, so it is not trusted until armed.
                if (scan_armed && scan_done) begin
                    scan_hit  = 1'b1;
                    state_nxt = pivot_bad ? FIN : ISSUE;
                end
            end
            ISSUE: if (piv_ready) state_nxt = NEXT;
            NEXT:  state_nxt = last_col ? FIN : LOAD;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_cnt        <= '0;
            singular      <= 1'b0;
            piv_row       <= '0;
            piv_swap      <= 1'b0;
            scan_armed    <= 1'b0;
            scan_done_rst <= 1'b0;
        end else begin
            scan_armed    <= (state == SCAN);
            scan_done_rst <= scan_take;

            if (start_acc) begin
                op_cnt   <= '0;
                singular <= 1'b0;
            end else if ((state == NEXT) && !abort && !last_col) begin
                op_cnt <= op_cnt + IDX_W'(1);
            end

            if (scan_take) begin
                piv_row  <= scan_winner;
                piv_swap <= (scan_winner != op_cnt);
                if (pivot_bad) begin
                    singular <= 1'b1;
                end
            end
        end
    end

    // Strobes are decoded from the registered state; abort masks the ones
    // that must drop in the same cycle abort is seen.
    assign busy       = (state != IDLE) && (state != FIN);
    assign done       = (state == FIN)   && !abort;
    assign col_rd     = (state == LOAD)  && !abort;
    assign scan_start = (state == START) && !abort;
    assign piv_valid  = (state == ISSUE) && !abort;
    assign col_idx    = op_cnt;
    assign piv_col    = op_cnt;

endmodule
